// File: rtl/align_if.sv
// Operand/result handshake bundle for the FP-adder alignment stage.
// The master side is the operand source and the result sink; the slave side is the aligner.
interface align_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 28
);
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic [MAN_W-1:0] mantis_a;
  logic [MAN_W-1:0] mantis_b;
  logic [2:0]       type_a;
  logic [2:0]       type_b;

  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] exp;
  logic [MAN_W-1:0] mantis_great;
  logic [MAN_W-1:0] mantis_small;
  logic             sticky;
  logic             a_is_great;
  logic             is_inf;
  logic             is_nan;

  modport master (
    output in_valid, exp_a, exp_b, mantis_a, mantis_b, type_a, type_b, out_ready,
    input  in_ready, out_valid, exp, mantis_great, mantis_small, sticky, a_is_great,
           is_inf, is_nan
  );

  modport slave (
    input  in_valid, exp_a, exp_b, mantis_a, mantis_b, type_a, type_b, out_ready,
    output in_ready, out_valid, exp, mantis_great, mantis_small, sticky, a_is_great,
           is_inf, is_nan
  );
endinterface

// File: rtl/align_pipe.sv
// Three-stage operand alignment for the FP adder: extend/compare, shift with sticky, order.
// All stages share one advance enable, so a stalled output freezes the whole pipe.
module align_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 28
) (
  input  logic    clk,
  input  logic    rst,
  align_if.slave  bus
);

  localparam logic [2:0] TZero = 3'b000;
  localparam logic [2:0] TNorm = 3'b001;
  localparam logic [2:0] TSub  = 3'b010;
  localparam logic [2:0] TInf  = 3'b011;
  localparam logic [MAN_W-1:0] HiddenBit = {2'b01, {(MAN_W-2){1'b0}}};

  typedef struct packed {
    logic [MAN_W-1:0] man;
    logic [EXP_W-1:0] eexp;
    logic             inf;
    logic             nan;
  } ext_t;

  // Codes outside the defined set fall into the nan branch.
  function automatic ext_t extend(input logic [2:0] typ, input logic [EXP_W-1:0] e,
                                  input logic [MAN_W-1:0] m);
    ext_t r;
    r.man  = '0;
    r.eexp = e;
    r.inf  = 1'b0;
    r.nan  = 1'b0;
    case (typ)
      TZero: r.eexp = '0;
      TNorm: r.man  = m | HiddenBit;
      TSub: begin
        r.man  = m;
        r.eexp = EXP_W'(1);
      end
      TInf:    r.inf = 1'b1;
      default: r.nan = 1'b1;
    endcase
    return r;
  endfunction

  logic w_en;

  // Stage 1 registers
  logic             r_v1, r_shift_a1, r_inf1, r_nan1;
  logic [MAN_W-1:0] r_keep1, r_shift1;
  logic [EXP_W-1:0] r_diff1, r_exp1;
  // Stage 2 registers
  logic             r_v2, r_shift_a2, r_sticky2, r_inf2, r_nan2;
  logic [MAN_W-1:0] r_keep2, r_shifted2;
  logic [EXP_W-1:0] r_exp2;
  // Stage 3 registers (outputs)
  logic             r_v3, r_sticky3, r_a_great3, r_inf3, r_nan3;
  logic [MAN_W-1:0] r_great3, r_small3;
  logic [EXP_W-1:0] r_exp3;

  assign w_en         = ~r_v3 | bus.out_ready;
  assign bus.in_ready = w_en;

  // Stage 1: extend and pick which operand gets shifted.
  ext_t             w_ext_a, w_ext_b;
  logic             w_a_ge;
  logic [MAN_W-1:0] w_keep, w_shift;
  logic [EXP_W-1:0] w_diff, w_big_exp;

  always_comb begin
    w_ext_a   = extend(bus.type_a, bus.exp_a, bus.mantis_a);
    w_ext_b   = extend(bus.type_b, bus.exp_b, bus.mantis_b);
    w_a_ge    = w_ext_a.eexp >= w_ext_b.eexp;
    w_keep    = w_a_ge ? w_ext_a.man : w_ext_b.man;
    w_shift   = w_a_ge ? w_ext_b.man : w_ext_a.man;
    w_diff    = w_a_ge ? (w_ext_a.eexp - w_ext_b.eexp) : (w_ext_b.eexp - w_ext_a.eexp);
    w_big_exp = w_a_ge ? w_ext_a.eexp : w_ext_b.eexp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_shift_a1 <= 1'b0;
      r_inf1     <= 1'b0;
      r_nan1     <= 1'b0;
      r_keep1    <= '0;
      r_shift1   <= '0;
      r_diff1    <= '0;
      r_exp1     <= '0;
    end else if (w_en) begin
      r_v1       <= bus.in_valid;
      r_shift_a1 <= ~w_a_ge;
      r_inf1     <= w_ext_a.inf | w_ext_b.inf;
      r_nan1     <= w_ext_a.nan | w_ext_b.nan;
      r_keep1    <= w_keep;
      r_shift1   <= w_shift;
      r_diff1    <= w_diff;
      r_exp1     <= w_big_exp;
    end
  end

  // Stage 2: right shift; a full-width diff saturates instead of wrapping.
  logic             w_sat, w_sticky;
  logic [MAN_W-1:0] w_shifted, w_lost_mask;

  always_comb begin
    w_sat       = 32'(r_diff1) >= MAN_W;
    w_lost_mask = ~({MAN_W{1'b1}} << r_diff1);
    w_shifted   = w_sat ? '0 : (r_shift1 >> r_diff1);
    w_sticky    = w_sat ? (|r_shift1) : (|(r_shift1 & w_lost_mask));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2       <= 1'b0;
      r_shift_a2 <= 1'b0;
      r_sticky2  <= 1'b0;
      r_inf2     <= 1'b0;
      r_nan2     <= 1'b0;
      r_keep2    <= '0;
      r_shifted2 <= '0;
      r_exp2     <= '0;
    end else if (w_en) begin
      r_v2       <= r_v1;
      r_shift_a2 <= r_shift_a1;
      r_sticky2  <= w_sticky;
      r_inf2     <= r_inf1;
      r_nan2     <= r_nan1;
      r_keep2    <= r_keep1;
      r_shifted2 <= w_shifted;
      r_exp2     <= r_exp1;
    end
  end

  // Stage 3: order; a tie keeps the unshifted operand on top.
  logic w_keep_ge;
  assign w_keep_ge = r_keep2 >= r_shifted2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3       <= 1'b0;
      r_sticky3  <= 1'b0;
      r_a_great3 <= 1'b0;
      r_inf3     <= 1'b0;
      r_nan3     <= 1'b0;
      r_great3   <= '0;
      r_small3   <= '0;
      r_exp3     <= '0;
    end else if (w_en) begin
      r_v3       <= r_v2;
      r_sticky3  <= r_sticky2;
      r_a_great3 <= w_keep_ge ? ~r_shift_a2 : r_shift_a2;
      r_inf3     <= r_inf2;
      r_nan3     <= r_nan2;
      r_great3   <= w_keep_ge ? r_keep2 : r_shifted2;
      r_small3   <= w_keep_ge ? r_shifted2 : r_keep2;
      r_exp3     <= r_exp2;
    end
  end

  assign bus.out_valid    = r_v3;
  assign bus.exp          = r_exp3;
  assign bus.mantis_great = r_great3;
  assign bus.mantis_small = r_small3;
  assign bus.sticky       = r_sticky3;
  assign bus.a_is_great   = r_a_great3;
  assign bus.is_inf       = r_inf3;
  assign bus.is_nan       = r_nan3;

endmodule

// File: tb/tb_align_pipe.sv
// Bench for align_pipe: hand-computed vector table streamed through a scoreboard,
// plus stall, mid-stream reset and latency sequences.
module tb_align_pipe;
  localparam int unsigned EW = 8;
  localparam int unsigned MW = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  align_if #(.EXP_W(EW), .MAN_W(MW)) bus ();

  align_pipe #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0]  ea, eb;
    logic [27:0] ma, mb;
    logic [2:0]  ta, tb;
    logic [7:0]  x_exp;
    logic [27:0] x_great, x_small;
    logic        x_sticky, x_ag, x_inf, x_nan;
  } vec_t;

  vec_t vecs [11];
  int   sb [$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [95:0] dut_out();
    return {28'h0, bus.exp, bus.mantis_great, bus.mantis_small,
            bus.sticky, bus.a_is_great, bus.is_inf, bus.is_nan};
  endfunction

  function automatic logic [95:0] want_out(input int i);
    return {28'h0, vecs[i].x_exp, vecs[i].x_great, vecs[i].x_small,
            vecs[i].x_sticky, vecs[i].x_ag, vecs[i].x_inf, vecs[i].x_nan};
  endfunction

  // Scoreboard: pop on every output handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output got=%h want=none", dut_out());
      end else begin
        int id;
        id = sb.pop_front();
        check($sformatf("vec%0d", id), dut_out(), want_out(id));
      end
    end
  end

  task automatic send(input int i);
    int n;
    bit acc;
    bus.exp_a    = vecs[i].ea;
    bus.exp_b    = vecs[i].eb;
    bus.mantis_a = vecs[i].ma;
    bus.mantis_b = vecs[i].mb;
    bus.type_a   = vecs[i].ta;
    bus.type_b   = vecs[i].tb;
    bus.in_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (acc) sb.push_back(i);
    else begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=in_ready_low want=accept vec=%0d", i);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 96'(sb.size()), 96'd0);
  endtask

  initial begin
    int c0;
    logic [95:0] snap;

    // ea eb ma mb ta tb | exp great small sticky a_is_great inf nan
    vecs[0]  = '{8'd10, 8'd7, 28'h0, 28'h8, 3'd1, 3'd1,
                 8'd10, 28'h4000000, 28'h0800001, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8'd10, 8'd7, 28'h0, 28'h1, 3'd1, 3'd1,
                 8'd10, 28'h4000000, 28'h0800000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'd5, 8'd45, 28'h10, 28'h0, 3'd1, 3'd1,
                 8'd45, 28'h4000000, 28'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'd5, 8'd5, 28'h1, 28'h2, 3'd1, 3'd1,
                 8'd5, 28'h4000002, 28'h4000001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'd5, 8'd5, 28'h3, 28'h3, 3'd1, 3'd1,
                 8'd5, 28'h4000003, 28'h4000003, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{8'd255, 8'd255, 28'h5, 28'h7, 3'd3, 3'd4,
                 8'd255, 28'h0, 28'h0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{8'd255, 8'd0, 28'h0, 28'h1, 3'd1, 3'd1,
                 8'd255, 28'h4000000, 28'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8'd0, 8'd9, 28'h100, 28'hFFF, 3'd2, 3'd0,
                 8'd1, 28'h100, 28'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{8'd29, 8'd3, 28'h0, 28'h1, 3'd1, 3'd1,
                 8'd29, 28'h4000000, 28'h1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'd4, 8'd4, 28'h0, 28'h55, 3'd1, 3'd7,
                 8'd4, 28'h4000000, 28'h0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{8'd0, 8'd7, 28'h4, 28'h8, 3'd2, 3'd2,
                 8'd1, 28'h8, 28'h4, 1'b0, 1'b0, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.exp_a     = '0;
    bus.exp_b     = '0;
    bus.mantis_a  = '0;
    bus.mantis_b  = '0;
    bus.type_a    = '0;
    bus.type_b    = '0;

    #2;
    check("rst_out_valid", 96'(bus.out_valid), 96'd0);
    check("rst_outputs", dut_out(), 96'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("post_rst_in_ready", 96'(bus.in_ready), 96'd1);

    // Full-rate stream of the whole table.
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int i = 0; i < 11; i++) send(i);
    check("throughput_cycles", 96'(cyc - c0), 96'd11);
    bus.in_valid = 1'b0;
    drain("drain_stream");

    // Six pairs with out_ready low during cycles 4..7.
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 6; i++) send(i);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        snap = dut_out();
        check("stall_in_ready", 96'(bus.in_ready), 96'd0);
        check("stall_out_valid", 96'(bus.out_valid), 96'd1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_in_ready", 96'(bus.in_ready), 96'd0);
          check("stall_stable", dut_out(), snap);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Asynchronous reset with three items in flight.
    @(posedge clk);
    #1;
    send(0);
    send(1);
    send(2);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 96'(bus.out_valid), 96'd0);
    check("midrst_outputs", dut_out(), 96'd0);
    sb.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    send(3);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("latency_c1", 96'(bus.out_valid), 96'd0);
    @(negedge clk);
    check("latency_c2", 96'(bus.out_valid), 96'd0);
    @(negedge clk);
    check("latency_c3", 96'(bus.out_valid), 96'd1);
    drain("drain_after_rst");
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/align_pipe.md
# align_pipe

Parametrised, pipelined operand-alignment stage for the floating-point adder datapath. It sits between operand unpacking and the mantissa add/subtract stage. It extends both mantissas by operand type, selects the larger exponent, and right-shifts the other mantissa by the exponent difference while capturing a sticky bit. It then orders the two aligned mantissas into great/small. Unlike the earlier combinational aligner, it is a 3-stage pipeline with valid/ready flow control, generic widths, saturating shift and sticky/special-value outputs.

## Interface
- EXP_W, 8, exponent width
- MAN_W, 28, extended mantissa width; bit MAN_W-2 is the hidden-bit position, bit MAN_W-1 is the carry guard
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input operand pair valid
- in_ready  out  1  stage can accept input this cycle
- exp_a, exp_b  in  EXP_W  biased exponents
- mantis_a, mantis_b  in  MAN_W  raw mantissas; the hidden bit is not set
- type_a, type_b  in  3  operand class: 000 zero, 001 normal, 010 subnormal, 011 inf, 100 nan; other codes are treated as nan
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- exp  out  EXP_W  aligned (larger) exponent
- mantis_great, mantis_small  out  MAN_W  ordered aligned mantissas
- sticky  out  1  OR of bits shifted out of the shifted mantissa
- a_is_great  out  1  mantis_great originated from operand a
- is_inf, is_nan  out  1  special-value flags (either operand inf / either operand nan)

## Operation
- Global advance enable: en = ~out_valid | out_ready. in_ready = en. All three stages advance together when en=1 and hold otherwise. Bubbles propagate as valid=0.
- S1 (extend + exponent compare):
  - normal: OR bit MAN_W-2 into the mantissa.
  - subnormal: mantissa unchanged, effective exponent = 1.
  - zero: mantissa forced 0, effective exponent = 0.
  - inf/nan: mantissa forced 0, set the matching flag.
  - Select: if eff_exp_a >= eff_exp_b, shift b, else shift a. diff = |eff_exp_a - eff_exp_b|, EXP_W bits, unsigned.
- S2 (shift): shifted = m_shift >> diff. If diff >= MAN_W, shifted = 0 and sticky = |m_shift. Otherwise sticky = OR of the diff LSBs of m_shift. exp = larger effective exponent.
- S3 (order): if nonshifted >= shifted (unsigned), great = nonshifted, else swap. On a tie, great = nonshifted. a_is_great is set from the original operand identity.
- Flags is_inf/is_nan travel with their data. Mantissa outputs are still produced when a flag is set (both 0 for inf/nan operands).

## Timing
- Latency 3 cycles from an accepted input (in_valid & in_ready) to out_valid, with no stall.
- Throughput 1 per cycle when out_ready stays high.
- out_valid=1 & out_ready=0: all stages hold. Outputs stay stable until the transfer. in_ready=0 in the same cycle (combinational from out_ready).
- An input is captured only when in_valid & in_ready. in_valid while in_ready=0 is ignored; the source must hold it.
- Reset (async assert, any cycle including mid-stream): all valid bits, exp, mantis_great, mantis_small, sticky, a_is_great, is_inf and is_nan go to 0 immediately. In-flight data is discarded. in_ready=1 once rst deasserts.
- Widths: diff uses the full EXP_W. There is no wrap: diff=255 with MAN_W=28 is the saturated case.

## Test plan
- Basic align (EXP_W=8, MAN_W=28): a exp 10 mantis 0x0000000 normal, b exp 7 mantis 0x0000008 normal -> after 3 cycles exp=10, great=0x4000000, small=0x0800001, sticky=0, a_is_great=1.
- Sticky: a exp 10 0x0000000 normal, b exp 7 0x0000001 normal -> small=0x0800000, sticky=1.
- Saturation and swap: a exp 5 0x0000010 normal, b exp 45 0x0000000 normal -> exp=45, great=0x4000000, small=0, sticky=1, a_is_great=0.
- Equal exponents with swap: both exp 5, a 0x0000001, b 0x0000002 normal -> great=0x4000002, small=0x4000001, a_is_great=0. Identical operands -> a_is_great=1 (shift b, tie keeps nonshifted).
- Flow control: stream 6 pairs, hold out_ready=0 for cycles 4-7 -> in_ready=0 during the stall, outputs stable, all 6 results appear in order, none dropped or duplicated. Specials: a inf, b nan -> is_inf=1, is_nan=1, both mantissas 0.
- Reset mid-stream: assert rst with 3 items in flight -> out_valid=0 and outputs 0 asynchronously. After release, the first new input emerges exactly 3 cycles after acceptance.
